// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the memory-game controller.
//   - state codes S_INIT .. S_RESULT (3-bit, also shown on debug LEDs)
//   - hold counter width for the PREP reset stretch
//   - control strobe bundle and its Moore decode from the state code
package game_pkg;

  localparam int STATE_W = 3;
  localparam int HOLD_W  = 28;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 3'd0,
    S_SETUP  = 3'd1,
    S_PREP   = 3'd2,
    S_SEQ    = 3'd3,
    S_PLAY   = 3'd4,
    S_CHECK  = 3'd5,
    S_NEXT   = 3'd6,
    S_RESULT = 3'd7
  } state_e;

  // Datapath control strobes driven by the controller.
  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } ctrl_t;

  // Strobes asserted in a given state. Anything unrecognised falls back to
  // the INIT pattern so the datapath is held in reset.
  function automatic ctrl_t decode_ctrl(input state_e st);
    ctrl_t c;
    c.r1  = 1'b0;
    c.r2  = 1'b0;
    c.e1  = 1'b0;
    c.e2  = 1'b0;
    c.e3  = 1'b0;
    c.e4  = 1'b0;
    c.sel = 1'b1;
    case (st)
      S_INIT: begin
        c.r1 = 1'b1;
        c.r2 = 1'b1;
      end
      S_SETUP:  c.e1  = 1'b1;
      S_PREP:   c.r2  = 1'b1;
      S_SEQ:    c.e3  = 1'b1;
      S_PLAY:   c.e2  = 1'b1;
      S_CHECK:  c.sel = 1'b1;
      S_NEXT:   c.e4  = 1'b1;
      S_RESULT: c.sel = 1'b0;
      default: begin
        c.r1 = 1'b1;
        c.r2 = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that times the PREP reset stretch.
// Ports:
//   clock_50  in   system clock
//   reset     in   synchronous active-low reset (counter -> 0)
//   load      in   load load_val this cycle (has priority over counting)
//   load_val  in   value to load (HOLD_W bits)
//   zero      out  counter currently equals 0
// The counter decrements once per cycle while non-zero and then parks at 0,
// so it can never underflow.
module hold_timer
  import game_pkg::*;
(
  input  logic              clock_50,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  output logic              zero
);

  logic [HOLD_W-1:0] count_r;

  // Counter register: reset, load, or count down towards zero.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      count_r <= {HOLD_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {HOLD_W{1'b0}}) begin
      count_r <= count_r - HOLD_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {HOLD_W{1'b0}});

endmodule

// File: rtl/game_controller.sv
// game_controller: control FSM for the memory-game datapath.
// Ports:
//   clock_50   in   50 MHz system clock
//   reset      in   synchronous active-low reset
//   enter      in   synchronised button level (edge-detected here)
//   end_fpga   in   FPGA playback finished
//   end_user   in   user finished entering the round
//   end_time   in   user input time expired
//   win        in   final round reached
//   match      in   user sequence equals FPGA sequence
//   r1, r2     out  global / per-round datapath resets
//   e1..e4     out  setup load, user entry, playback, round increment
//   sel        out  display select (1 game info, 0 result text)
//   state      out  current state code for debug LEDs
// The per-round reset r2 is held for P_HOLD cycles in PREP so that registers
// on the slow game clock are sure to see it.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned P_HOLD = 32'd200_000_000
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               enter,
  input  logic               end_fpga,
  input  logic               end_user,
  input  logic               end_time,
  input  logic               win,
  input  logic               match,
  output logic               r1,
  output logic               r2,
  output logic               e1,
  output logic               e2,
  output logic               e3,
  output logic               e4,
  output logic               sel,
  output logic [STATE_W-1:0] state
);

  // Counter is loaded with P_HOLD-1 so PREP lasts exactly P_HOLD cycles.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(P_HOLD - 32'd1);

  state_e state_r;
  state_e next_state_s;
  ctrl_t  ctrl_r;
  ctrl_t  next_ctrl_s;
  logic   enter_q_r;
  logic   enter_rise_s;
  logic   hold_load_s;
  logic   hold_zero_s;

  hold_timer u_hold_timer (
    .clock_50 (clock_50),
    .reset    (reset),
    .load     (hold_load_s),
    .load_val (HOLD_LOAD),
    .zero     (hold_zero_s)
  );

  // Button edge detector; resets high so a button held through reset is not a press.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      enter_q_r <= 1'b1;
    end else begin
      enter_q_r <= enter;
    end
  end

  assign enter_rise_s = enter & ~enter_q_r;

  // State register.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; also requests a hold counter load on every PREP entry.
  always_comb begin
    next_state_s = state_r;
    hold_load_s  = 1'b0;
    case (state_r)
      S_INIT: next_state_s = S_SETUP;
      S_SETUP: begin
        if (enter_rise_s) begin
          next_state_s = S_PREP;
          hold_load_s  = 1'b1;
        end else begin
          next_state_s = S_SETUP;
        end
      end
      S_PREP: begin
        if (hold_zero_s) begin
          next_state_s = S_SEQ;
        end else begin
          next_state_s = S_PREP;
        end
      end
      S_SEQ: begin
        if (end_fpga) begin
          next_state_s = S_PLAY;
        end else begin
          next_state_s = S_SEQ;
        end
      end
      S_PLAY: begin
        // Timeout wins over a simultaneous end of user entry.
        if (end_time) begin
          next_state_s = S_RESULT;
        end else if (end_user) begin
          next_state_s = S_CHECK;
        end else begin
          next_state_s = S_PLAY;
        end
      end
      S_CHECK: begin
        if (match) begin
          next_state_s = S_NEXT;
        end else begin
          next_state_s = S_RESULT;
        end
      end
      S_NEXT: begin
        // win reflects the round just completed (counter not yet incremented).
        if (win) begin
          next_state_s = S_RESULT;
        end else begin
          next_state_s = S_PREP;
          hold_load_s  = 1'b1;
        end
      end
      S_RESULT: begin
        if (enter_rise_s) begin
          next_state_s = S_INIT;
        end else begin
          next_state_s = S_RESULT;
        end
      end
      default: next_state_s = S_INIT;
    endcase
    next_ctrl_s = decode_ctrl(next_state_s);
  end

  // Output register: decoded from the next state so it always matches state_r.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      ctrl_r <= decode_ctrl(S_INIT);
    end else begin
      ctrl_r <= next_ctrl_s;
    end
  end

  assign r1    = ctrl_r.r1;
  assign r2    = ctrl_r.r2;
  assign e1    = ctrl_r.e1;
  assign e2    = ctrl_r.e2;
  assign e3    = ctrl_r.e3;
  assign e4    = ctrl_r.e4;
  assign sel   = ctrl_r.sel;
  assign state = state_r;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural model of the game flow.
module tb_game_controller;

  localparam int P_HOLD = 4;

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       enter    = 1'b0;
  logic       end_fpga = 1'b0;
  logic       end_user = 1'b0;
  logic       end_time = 1'b0;
  logic       win      = 1'b0;
  logic       match    = 1'b0;
  logic       r1, r2, e1, e2, e3, e4, sel;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: phase number, cycles spent in the current hold, last enter.
  int m_phase    = 0;
  int m_prep_cnt = 0;
  bit m_enter_prev = 1'b1;

  game_controller #(.P_HOLD(P_HOLD)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .enter    (enter),
    .end_fpga (end_fpga),
    .end_user (end_user),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .r1       (r1),
    .r2       (r2),
    .e1       (e1),
    .e2       (e2),
    .e3       (e3),
    .e4       (e4),
    .sel      (sel),
    .state    (state)
  );

  always #10 clock_50 = ~clock_50;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit rise;
    if (!reset) begin
      m_phase      = 0;
      m_prep_cnt   = 0;
      m_enter_prev = 1'b1;
    end else begin
      rise = enter && !m_enter_prev;
      m_enter_prev = enter;
      case (m_phase)
        0: m_phase = 1;
        1: if (rise) begin m_phase = 2; m_prep_cnt = 1; end
        2: begin
          if (m_prep_cnt == P_HOLD) m_phase = 3;
          else m_prep_cnt++;
        end
        3: if (end_fpga) m_phase = 4;
        4: begin
          if (end_time) m_phase = 7;
          else if (end_user) m_phase = 5;
        end
        5: m_phase = match ? 6 : 7;
        6: begin
          if (win) m_phase = 7;
          else begin m_phase = 2; m_prep_cnt = 1; end
        end
        7: if (rise) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  endtask

  // Expected {state, r1, r2, e1, e2, e3, e4, sel} for the model phase.
  function automatic logic [15:0] model_outs();
    logic [15:0] v;
    v = 16'd0;
    v[9:7] = 3'(m_phase);
    v[6]   = (m_phase == 0);
    v[5]   = (m_phase == 0) || (m_phase == 2);
    v[4]   = (m_phase == 1);
    v[3]   = (m_phase == 4);
    v[2]   = (m_phase == 3);
    v[1]   = (m_phase == 6);
    v[0]   = (m_phase != 7);
    return v;
  endfunction

  task automatic tick();
    logic [15:0] obs;
    @(posedge clock_50);
    model_step();
    cyc++;
    #1;
    obs = {6'd0, state, r1, r2, e1, e2, e3, e4, sel};
    check_val("outs", obs, model_outs());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int prep_seen;
    int e4_cnt;

    // Reset and release.
    run(2);
    check_val("rst_state", 16'(state), 16'd0);
    check_val("rst_r1r2", 16'({r1, r2, sel}), 16'b111);
    reset = 1'b1;
    tick();
    check_val("setup_state", 16'(state), 16'd1);
    check_val("setup_e1", 16'(e1), 16'd1);

    // Enter held for 10 cycles: one transition, PREP lasts exactly 4 cycles.
    enter = 1'b1;
    prep_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state == 3'd2 && r2) prep_seen++;
    end
    enter = 1'b0;
    check_val("prep_len", 16'(prep_seen), 16'(P_HOLD));
    check_val("seq_e3", 16'({state, e3}), {12'd0, 3'd3, 1'b1});

    // Playback, then a matching round that is not the last.
    run(7);
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    check_val("play_e2", 16'({state, e2}), {12'd0, 3'd4, 1'b1});
    end_user = 1'b1;
    match    = 1'b1;
    tick();
    end_user = 1'b0;
    e4_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (e4) e4_cnt++;
    end
    check_val("e4_pulse", 16'(e4_cnt), 16'd1);
    check_val("back_prep", 16'({state, r2}), {12'd0, 3'd2, 1'b1});
    match = 1'b0;
    run(3);
    check_val("prep2_exit", 16'(state), 16'd3);

    // Timeout and user-done together: timeout wins.
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    end_time = 1'b1;
    end_user = 1'b1;
    tick();
    end_time = 1'b0;
    end_user = 1'b0;
    check_val("tmo_result", 16'({state, sel}), {12'd0, 3'd7, 1'b0});
    run(3);
    enter = 1'b1;
    tick();
    check_val("result_init", 16'(state), 16'd0);
    tick();
    enter = 1'b0;
    tick();
    check_val("no_stale_enter", 16'(state), 16'd1);

    // Mismatch goes straight to RESULT.
    enter = 1'b1;
    tick();
    enter = 1'b0;
    run(4);
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    end_user = 1'b1;
    match    = 1'b0;
    run(2);
    end_user = 1'b0;
    check_val("mismatch", 16'(state), 16'd7);

    // Final round: NEXT pulses e4 then RESULT.
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    run(4);
    end_fpga = 1'b1;
    tick();
    end_fpga = 1'b0;
    end_user = 1'b1;
    match    = 1'b1;
    win      = 1'b1;
    run(2);
    check_val("final_e4", 16'({state, e4}), {12'd0, 3'd6, 1'b1});
    tick();
    check_val("final_result", 16'(state), 16'd7);
    end_user = 1'b0;
    match    = 1'b0;
    win      = 1'b0;

    // Reset in the middle of the PREP hold.
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_val("mid_rst", 16'({state, r1}), {12'd0, 3'd0, 1'b1});
    reset = 1'b1;
    run(4);
    check_val("no_stale_hold", 16'(state), 16'd1);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    run(3);
    check_val("fresh_hold", 16'(state), 16'd2);
    tick();
    check_val("fresh_exit", 16'(state), 16'd3);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 149) != 0);
      enter    = ($urandom_range(0, 3) == 0);
      end_fpga = ($urandom_range(0, 3) == 0);
      end_user = ($urandom_range(0, 4) == 0);
      end_time = ($urandom_range(0, 6) == 0);
      win      = ($urandom_range(0, 2) == 0);
      match    = ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
